// File: rtl/booth_seq_5_if.sv
// Operand/result bundle for the sequential radix-4 Booth multiplier.
// Valid/ready: a start pulse is taken only while busy=0 and rdy=0 (IDLE); rdy is a one-cycle product-valid pulse.
interface booth_seq_5_if;
    logic        start;
    logic [11:0] mult_a;
    logic [11:0] mult_b;
    logic        busy;
    logic        rdy;
    logic [23:0] product;
    logic [1:0]  state_dbg;

    modport master (
        output start, mult_a, mult_b,
        input  busy, rdy, product, state_dbg
    );

    modport slave (
        input  start, mult_a, mult_b,
        output busy, rdy, product, state_dbg
    );
endinterface

// File: rtl/booth_seq_5.sv
// Sequential 12x12 signed multiplier, one radix-4 Booth digit per cycle,
// six RUN cycles per operation followed by a single DONE cycle.
module booth_seq_5 (
    input  logic          clk,
    input  logic          rst_n,
    booth_seq_5_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] a_q;
    logic [11:0] b_q;
    logic [23:0] acc;
    logic [2:0]  k;
    logic        busy_q;
    logic        rdy_q;
    logic [23:0] prod_q;

    logic [12:0] b_ext;
    logic [2:0]  trip;
    logic [23:0] a_ext;
    logic [23:0] pp;
    logic [23:0] sum;

    // b[-1] is the appended zero, so the triplet for digit k starts at bit 2k of b_ext
    always_comb begin
        b_ext = {b_q, 1'b0};
        trip  = b_ext[{k, 1'b0} +: 3];
        a_ext = {{12{a_q[11]}}, a_q};
        pp    = '0;
        case (trip)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        sum = acc + (pp << {k, 1'b0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            k      <= '0;
            busy_q <= 1'b0;
            rdy_q  <= 1'b0;
            prod_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.mult_a;
                        b_q    <= bus.mult_b;
                        acc    <= '0;
                        k      <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum;
                    k   <= k + 3'd1;
                    if (k == 3'd5) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        rdy_q  <= 1'b1;
                        prod_q <= sum;
                    end
                end
                DONE: begin
                    rdy_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rdy       = rdy_q;
    assign bus.product   = prod_q;
    assign bus.state_dbg = state;
endmodule

// File: doc/booth_seq_5.md
BOOTH_SEQ_5 -- requirements
Module: booth_seq_5

Interface
REQ-001 The module SHALL have no parameters; widths are fixed at 12-bit operands and a 24-bit product.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; operands are sampled on the same edge.
REQ-005 mult_a  input  12  signed two's-complement multiplicand.
REQ-006 mult_b  input  12  signed two's-complement multiplier, radix-4 Booth recoded.
REQ-007 busy  output  1  high while iterations are in progress.
REQ-008 rdy  output  1  one-cycle pulse; product is valid.
REQ-009 product  output  24  signed product mult_a*mult_b; holds until the next completion.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 In IDLE, start=1 SHALL latch mult_a and mult_b, clear the accumulator, set the digit index k=0 and go to RUN.
REQ-012 In IDLE, start=0 SHALL keep the state, accumulator and product unchanged.
REQ-013 In RUN, each cycle SHALL form the triplet {b[2k+1], b[2k], b[2k-1]} from the latched multiplier, with b[-1]=0.
REQ-014 Booth digit mapping: 000,111 -> 0; 001,010 -> +A; 011 -> +2A; 100 -> -2A; 101,110 -> -A.
REQ-015 A SHALL be sign-extended to 24 bits before negation or doubling, so A=-2048 yields +2048 and +4096 without overflow.
REQ-016 Each RUN cycle SHALL add (digit*A)<<(2k) to the 24-bit accumulator, modulo 2^24.
REQ-017 The add SHALL use the triplet of the current k, and k SHALL increment once per RUN cycle.
REQ-018 After the RUN cycle with k=5 (six digits), the FSM SHALL go to DONE on that edge.
REQ-019 On that same edge, product SHALL take the final sum and rdy SHALL rise.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE with rdy=0.
REQ-021 busy SHALL be 1 exactly while the state is RUN: six cycles per operation.
REQ-022 Latency: start sampled at edge E0 -> rdy high and product valid after edge E6.
REQ-023 start SHALL be ignored in RUN and DONE; there is no queuing, and the latched operands are unaffected.
REQ-024 Operand changes after the start edge SHALL NOT affect the result.
REQ-025 Back-to-back: start asserted in the IDLE cycle right after DONE SHALL be accepted, giving a minimum issue interval of 8 cycles.
REQ-026 product SHALL hold its last value through IDLE, DONE and RUN of a subsequent operation, until the next rdy.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, busy=0, rdy=0, product=0, accumulator=0, k=0 and latched operands=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no rdy pulse.
REQ-029 After reset release, the first start SHALL behave as a fresh operation.
REQ-030 start held high during reset SHALL be ignored until the first rising edge with rst_n=1.

Verification
REQ-031 Basic: a=5, b=3, one start pulse -> busy high 6 cycles, rdy pulse at E6, product=0x00000F.
REQ-032 Extreme negative: a=-2048, b=-2048 -> product=0x400000; a=2047, b=-2048 -> product=0xC00800.
REQ-033 Sign/zero: a=-1, b=-1 -> 0x000001; a=0x7FF, b=0 -> 0x000000; a=-3, b=7 -> 0xFFFFEB.
REQ-034 Busy ignore: second start with different operands at E3 -> first result unchanged, exactly one rdy pulse.
REQ-035 Reset mid-op: rst_n low during RUN cycle 3 -> all outputs 0 immediately, no rdy; the next start (a=5, b=3) gives 0x00000F.
REQ-036 Random regression: at least 10k random signed pairs, back-to-back starts -> every product equals the 24-bit signed a*b and busy/rdy timing matches REQ-021/REQ-022.
